// File: rtl/tile_map_renderer_if.sv
`default_nettype none
// ============================================================================
// Module   : tile_map_renderer_if
// Brief    : Scan-coordinate, tile-lookup and pixel-output bundle of the tile layer.
// Revision : 1.0
// ============================================================================
interface tile_map_renderer_if;
    logic [10:0] pixelX;
    logic [10:0] pixelY;
    logic        pixelValid;
    logic        startOfFrame;
    logic [2:0]  Xnum;
    logic [2:0]  Ynum;
    logic [1:0]  Tile_Type;
    logic        drawingRequest;
    logic [7:0]  RGBout;

    // The renderer is the slave; the scan generator / map / mux side is master.
    modport slave (
        input  pixelX, pixelY, pixelValid, startOfFrame, Tile_Type,
        output Xnum, Ynum, drawingRequest, RGBout
    );

    modport master (
        output pixelX, pixelY, pixelValid, startOfFrame, Tile_Type,
        input  Xnum, Ynum, drawingRequest, RGBout
    );
endinterface
`default_nettype wire

// File: rtl/tile_map_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tile_map_renderer
// Brief    : Two-stage pipeline mapping scan coordinates to tile indices and tile colour.
// Revision : 1.0
// ============================================================================
module tile_map_renderer #(
    parameter int                 TILE_LOG2    = 5,
    parameter logic signed [10:0] ORIGIN_X     = 11'sd64,
    parameter logic signed [10:0] ORIGIN_Y     = 11'sd112,
    parameter int                 FLASH_FRAMES = 16,
    parameter logic [7:0]         BRICK_RGB    = 8'hE0,
    parameter logic [7:0]         BORDER_RGB   = 8'h60,
    parameter logic [7:0]         SPIKE_RGB    = 8'hFC,
    parameter logic [7:0]         FLASH_RGB    = 8'h1F
) (
    input  logic              clk,
    input  logic              reset,
    tile_map_renderer_if.slave bus
);
    localparam logic [11:0] C_MAP_PIX  = 12'(8 << TILE_LOG2);
    localparam logic [7:0]  C_LAST_CNT = 8'(FLASH_FRAMES - 1);

    logic [11:0]          w_dx, w_dy;
    logic                 w_inside;

    logic [2:0]           xnum_q, xnum_d, ynum_q, ynum_d;
    logic [TILE_LOG2-1:0] offx_q, offx_d, offy_q, offy_d;
    logic                 v1_q, v1_d;
    logic                 req_q, req_d;
    logic [7:0]           rgb_q, rgb_d;
    logic [7:0]           cnt_q, cnt_d;
    logic                 phase_q, phase_d;

    // Sign-extend to 12 bits so negative and far-off coordinates cannot alias into the map.
    assign w_dx     = {bus.pixelX[10], bus.pixelX} - {ORIGIN_X[10], ORIGIN_X};
    assign w_dy     = {bus.pixelY[10], bus.pixelY} - {ORIGIN_Y[10], ORIGIN_Y};
    assign w_inside = bus.pixelValid
                    && !w_dx[11] && (w_dx < C_MAP_PIX)
                    && !w_dy[11] && (w_dy < C_MAP_PIX);

    always_comb begin
        xnum_d = 3'd0;
        ynum_d = 3'd0;
        offx_d = '0;
        offy_d = '0;
        v1_d   = w_inside;
        if (w_inside) begin
            xnum_d = w_dx[TILE_LOG2+2:TILE_LOG2];
            ynum_d = w_dy[TILE_LOG2+2:TILE_LOG2];
            offx_d = w_dx[TILE_LOG2-1:0];
            offy_d = w_dy[TILE_LOG2-1:0];
        end
    end

    always_comb begin
        req_d = 1'b0;
        rgb_d = 8'h00;
        if (v1_q) begin
            case (bus.Tile_Type)
                2'b01: begin
                    req_d = 1'b1;
                    rgb_d = (offx_q == '0 || offy_q == '0) ? BORDER_RGB : BRICK_RGB;
                end
                2'b10: begin
                    req_d = 1'b1;
                    rgb_d = SPIKE_RGB;
                end
                2'b11: begin
                    req_d = phase_q;
                    rgb_d = phase_q ? FLASH_RGB : 8'h00;
                end
                default: begin
                    req_d = 1'b0;
                    rgb_d = 8'h00;
                end
            endcase
        end
    end

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        if (bus.startOfFrame) begin
            if (cnt_q == C_LAST_CNT) begin
                cnt_d   = 8'd0;
                phase_d = ~phase_q;
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            xnum_q  <= 3'd0;
            ynum_q  <= 3'd0;
            offx_q  <= '0;
            offy_q  <= '0;
            v1_q    <= 1'b0;
            req_q   <= 1'b0;
            rgb_q   <= 8'h00;
            cnt_q   <= 8'd0;
            phase_q <= 1'b0;
        end else begin
            xnum_q  <= xnum_d;
            ynum_q  <= ynum_d;
            offx_q  <= offx_d;
            offy_q  <= offy_d;
            v1_q    <= v1_d;
            req_q   <= req_d;
            rgb_q   <= rgb_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign bus.Xnum           = xnum_q;
    assign bus.Ynum           = ynum_q;
    assign bus.drawingRequest = req_q;
    assign bus.RGBout         = rgb_q;
endmodule
`default_nettype wire

// File: tb/tb_tile_map_renderer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_map_renderer
// Brief    : Directed self-checking bench for tile_map_renderer with a stub tile map.
// Revision : 1.0
// ============================================================================
module tb_tile_map_renderer;
    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    int   map_mode = 0;  // 0: all 01, 1: all 11, 2: even cols 10 / odd cols 00

    tile_map_renderer_if bus();

    tile_map_renderer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus.Tile_Type = 2'b00;
        case (map_mode)
            0:       bus.Tile_Type = 2'b01;
            1:       bus.Tile_Type = 2'b11;
            2:       bus.Tile_Type = bus.Xnum[0] ? 2'b00 : 2'b10;
            default: bus.Tile_Type = 2'b00;
        endcase
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int x, input int y, input logic v, input logic sof);
        bus.pixelX       = 11'(x);
        bus.pixelY       = 11'(y);
        bus.pixelValid   = v;
        bus.startOfFrame = sof;
    endtask

    // Single isolated pixel: indices checked one clock after sampling, colour two.
    task automatic single(input string tag, input int x, input int y,
                          input logic [2:0] ex, input logic [2:0] ey,
                          input logic ereq, input logic [7:0] ergb);
        @(negedge clk);
        drive(x, y, 1'b1, 1'b0);
        @(negedge clk);
        drive(0, 0, 1'b0, 1'b0);
        chk({tag, "_xnum"}, 16'(bus.Xnum), 16'(ex));
        chk({tag, "_ynum"}, 16'(bus.Ynum), 16'(ey));
        @(negedge clk);
        chk({tag, "_req"}, 16'(bus.drawingRequest), 16'(ereq));
        chk({tag, "_rgb"}, 16'(bus.RGBout), 16'(ergb));
    endtask

    initial begin
        reset = 1'b1;
        drive(64 + 32 * 3, 112 + 32 * 2, 1'b1, 1'b1);

        // Reset dominates valid pixels and frame pulses.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("rst_req",  16'(bus.drawingRequest), 16'h0);
            chk("rst_rgb",  16'(bus.RGBout),         16'h0);
            chk("rst_xnum", 16'(bus.Xnum),           16'h0);
            chk("rst_ynum", 16'(bus.Ynum),           16'h0);
        end
        reset = 1'b0;
        drive(0, 0, 1'b0, 1'b0);

        map_mode = 0;
        single("origin",   64,            112,            3'd0, 3'd0, 1'b1, 8'h60);
        single("brick",    64 + 96 + 5,   112 + 224 + 9,  3'd3, 3'd7, 1'b1, 8'hE0);
        single("border_y", 64 + 40,       112 + 64,       3'd1, 3'd2, 1'b1, 8'h60);
        single("border_x", 64 + 224,      112 + 255,      3'd7, 3'd7, 1'b1, 8'h60);
        single("left",     63,            112,            3'd0, 3'd0, 1'b0, 8'h00);
        single("brick2",   64 + 161,      112 + 33,       3'd5, 3'd1, 1'b1, 8'hE0);
        single("right",    64 + 256,      112,            3'd0, 3'd0, 1'b0, 8'h00);
        single("top",      64,            111,            3'd0, 3'd0, 1'b0, 8'h00);
        single("neg",      -1,            -1,             3'd0, 3'd0, 1'b0, 8'h00);
        single("below",    64 + 10,       112 + 256,      3'd0, 3'd0, 1'b0, 8'h00);

        // Reset in flight drops the pixel; next pixel still has 2-clock latency.
        @(negedge clk);
        drive(64 + 5, 112 + 5, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_req", 16'(bus.drawingRequest), 16'h0);
        single("post_rst", 64 + 5, 112 + 5, 3'd0, 3'd0, 1'b1, 8'hE0);

        // Flashing tile: phase flips after every 16 frame pulses.
        map_mode = 1;
        for (int k = 0; k <= 32; k++) begin
            @(negedge clk);
            drive(64 + 7, 112 + 7, 1'b1, 1'b0);
            @(negedge clk);
            @(negedge clk);
            chk($sformatf("flash_req_f%0d", k), 16'(bus.drawingRequest),
                16'((k >= 16 && k <= 31) ? 1 : 0));
            chk($sformatf("flash_rgb_f%0d", k), 16'(bus.RGBout),
                (k >= 16 && k <= 31) ? 16'h1F : 16'h00);
            if (k < 32) begin
                drive(64 + 7, 112 + 7, 1'b1, 1'b1);
                @(negedge clk);
                drive(64 + 7, 112 + 7, 1'b1, 1'b0);
                // The toggling pulse is not yet visible one edge later, only after the next.
                if (k == 15) begin
                    chk("flash_edge_n", 16'(bus.drawingRequest), 16'h0);
                    @(negedge clk);
                    chk("flash_edge_n1", 16'(bus.drawingRequest), 16'h1);
                end
            end
        end
        drive(0, 0, 1'b0, 1'b0);

        // Back-to-back stream across the map row and beyond its right edge.
        map_mode = 2;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 290; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                int  j;
                logic ereq;
                j    = i - 2;
                ereq = (j < 256) && (((j >> 5) & 1) == 0);
                chk($sformatf("stream_req_%0d", j), 16'(bus.drawingRequest), 16'(ereq));
                chk($sformatf("stream_rgb_%0d", j), 16'(bus.RGBout), ereq ? 16'hFC : 16'h00);
            end
            if (i < 288) drive(64 + i, 120, 1'b1, 1'b0);
            else         drive(0, 0, 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
